// File: rtl/alu_pkg.sv
// Shared ALU encodings, 1-bit slice operation codes and sequencer state type
// used by the serial ALU controller and its slice.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SLICE_AND = 2'b00;
  localparam logic [1:0] SLICE_OR  = 2'b01;
  localparam logic [1:0] SLICE_ADD = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  // SUB and SLT both subtract, so B is inverted and the carry seeds to 1.
  function automatic logic is_sub_like(input logic [3:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/result bundle of the serial ALU sequencer; abort_i exists only
// when ALU_SERIAL_ABORT_EN is defined.
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 32
) ();
  logic             start_i;
  logic [3:0]       ALU_control_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
`ifdef ALU_SERIAL_ABORT_EN
  logic             abort_i;
`endif
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             cout_o;
  logic             overflow_o;

  modport master (
    output start_i, ALU_control_i, src1_i, src2_i,
`ifdef ALU_SERIAL_ABORT_EN
    output abort_i,
`endif
    input  busy_o, done_o, result_o, zero_o, cout_o, overflow_o
  );

  modport slave (
    input  start_i, ALU_control_i, src1_i, src2_i,
`ifdef ALU_SERIAL_ABORT_EN
    input  abort_i,
`endif
    output busy_o, done_o, result_o, zero_o, cout_o, overflow_o
  );
endinterface

// File: rtl/alu_top.sv
// One-bit ALU slice: optional input inversion, then AND / OR / full-add / less.
module alu_top (
  input  logic       src1,
  input  logic       src2,
  input  logic       less,
  input  logic       A_invert,
  input  logic       B_invert,
  input  logic       cin,
  input  logic [1:0] operation,
  output logic       result,
  output logic       cout
);
  logic a, b;

  always_comb begin
    a    = src1 ^ A_invert;
    b    = src2 ^ B_invert;
    cout = (a & b) | (a & cin) | (b & cin);
    case (operation)
      2'b00:   result = a & b;
      2'b01:   result = a | b;
      2'b10:   result = a ^ b ^ cin;
      default: result = less;
    endcase
  end
endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: drives one alu_top slice LSB first for WIDTH cycles.
// Optional ALU_SERIAL_ABORT_EN adds abort_i to cancel a running operation.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input logic               clk_i,
  input logic               rst_i,
  alu_serial_ctrl_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]       op_q, op_d;
  logic             carry_q, carry_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, cout_q, cout_d;
  logic             ovf_out_q, ovf_out_d, done_q, done_d;

  logic [1:0] slice_op;
  logic       a_inv, b_inv, op_valid, op_addsub, op_arith;
  logic       slice_res, slice_cout;
  logic [WIDTH-1:0] final_res;

  // Opcode decode to slice controls; undefined codes run as AND and are zeroed at DONE.
  always_comb begin
    slice_op  = SLICE_AND;
    a_inv     = 1'b0;
    b_inv     = 1'b0;
    op_valid  = 1'b1;
    op_addsub = 1'b0;
    op_arith  = 1'b0;
    case (op_q)
      ALU_AND: slice_op = SLICE_AND;
      ALU_OR:  slice_op = SLICE_OR;
      ALU_ADD: begin slice_op = SLICE_ADD; op_addsub = 1'b1; op_arith = 1'b1; end
      ALU_SUB: begin slice_op = SLICE_ADD; b_inv = 1'b1; op_addsub = 1'b1; op_arith = 1'b1; end
      ALU_SLT: begin slice_op = SLICE_ADD; b_inv = 1'b1; op_arith = 1'b1; end
      ALU_NOR: begin slice_op = SLICE_AND; a_inv = 1'b1; b_inv = 1'b1; end
      default: op_valid = 1'b0;
    endcase
  end

  alu_top u_slice (
    .src1      (a_q[0]),
    .src2      (b_q[0]),
    .less      (1'b0),
    .A_invert  (a_inv),
    .B_invert  (b_inv),
    .cin       (carry_q),
    .operation (slice_op),
    .result    (slice_res),
    .cout      (slice_cout)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    op_d      = op_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    cout_d    = cout_q;
    ovf_out_d = ovf_out_q;
    done_d    = 1'b0;
    final_res = op_valid ? res_q : '0;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          a_d     = bus.src1_i;
          b_d     = bus.src2_i;
          op_d    = bus.ALU_control_i;
          carry_d = is_sub_like(bus.ALU_control_i);
          cnt_d   = '0;
          res_d   = '0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {slice_res, res_q[WIDTH-1:1]};
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          ovf_d   = op_arith & (carry_q ^ slice_cout);
          state_d = (op_q == ALU_SLT) ? FIX : DONE;
        end
      end
      FIX: begin
        res_d   = {{(WIDTH-1){1'b0}}, res_q[WIDTH-1] ^ ovf_q};
        state_d = DONE;
      end
      DONE: begin
        result_d  = final_res;
        zero_d    = (final_res == '0);
        cout_d    = op_addsub & carry_q;
        ovf_out_d = op_addsub & ovf_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef ALU_SERIAL_ABORT_EN
    if (bus.abort_i && (state_q == RUN || state_q == FIX)) begin
      state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      op_q      <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      cout_q    <= 1'b0;
      ovf_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      op_q      <= op_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      cout_q    <= cout_d;
      ovf_out_q <= ovf_out_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy_o     = (state_q == RUN) || (state_q == FIX);
  assign bus.done_o     = done_q;
  assign bus.result_o   = result_q;
  assign bus.zero_o     = zero_q;
  assign bus.cout_o     = cout_q;
  assign bus.overflow_o = ovf_out_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl (WIDTH=32); the abort
// steps are compiled in only with ALU_SERIAL_ABORT_EN.
module tb_alu_serial_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_serial_ctrl_if #(.WIDTH(32)) bus ();

  alu_serial_ctrl #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start and return the cycle (edges after acceptance) at which done_o rose.
  task automatic do_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    bus.start_i       = 1'b1;
    bus.ALU_control_i = ctrl;
    bus.src1_i        = a;
    bus.src2_i        = b;
    tick();
    bus.start_i = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.done_o) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int done_at;

    bus.start_i       = 1'b0;
    bus.ALU_control_i = 4'b0000;
    bus.src1_i        = '0;
    bus.src2_i        = '0;
`ifdef ALU_SERIAL_ABORT_EN
    bus.abort_i       = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;

    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_result", bus.result_o, 0);
    chk("rst_zero", bus.zero_o, 1);
    chk("rst_cout", bus.cout_o, 0);
    chk("rst_ovf", bus.overflow_o, 0);

    do_op(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    chk("add_lat", lat, 33);
    chk("add_res", bus.result_o, 32'h8000_0000);
    chk("add_ovf", bus.overflow_o, 1);
    chk("add_cout", bus.cout_o, 0);
    chk("add_zero", bus.zero_o, 0);
    tick();
    chk("add_done_pulse", bus.done_o, 0);
    chk("add_hold", bus.result_o, 32'h8000_0000);

    do_op(ALU_SUB, 32'h5, 32'h5, lat);
    chk("sub_eq_lat", lat, 33);
    chk("sub_eq_res", bus.result_o, 0);
    chk("sub_eq_zero", bus.zero_o, 1);
    chk("sub_eq_cout", bus.cout_o, 1);
    chk("sub_eq_ovf", bus.overflow_o, 0);

    do_op(ALU_SUB, 32'h0, 32'h1, lat);
    chk("sub_neg_res", bus.result_o, 32'hFFFF_FFFF);
    chk("sub_neg_cout", bus.cout_o, 0);
    chk("sub_neg_zero", bus.zero_o, 0);

    do_op(ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    chk("slt1_lat", lat, 34);
    chk("slt1_res", bus.result_o, 1);
    chk("slt1_cout", bus.cout_o, 0);
    chk("slt1_ovf", bus.overflow_o, 0);

    do_op(ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, lat);
    chk("slt2_lat", lat, 34);
    chk("slt2_res", bus.result_o, 0);
    chk("slt2_zero", bus.zero_o, 1);
    chk("slt2_ovf", bus.overflow_o, 0);

    do_op(ALU_NOR, 32'hF0F0_F0F0, 32'h0F0F_0F00, lat);
    chk("nor_res", bus.result_o, 32'h0000_000F);

    do_op(ALU_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, lat);
    chk("and_res", bus.result_o, 32'h0F0F_0000);

    do_op(ALU_OR, 32'hFFFF_0000, 32'h0F0F_0F0F, lat);
    chk("or_res", bus.result_o, 32'hFFFF_0F0F);
    chk("or_cout", bus.cout_o, 0);

    do_op(4'b1111, 32'h1234_5678, 32'hFFFF_FFFF, lat);
    chk("undef_lat", lat, 33);
    chk("undef_res", bus.result_o, 0);
    chk("undef_zero", bus.zero_o, 1);

    // start_i pulsed in cycle 10 of a running ADD must not queue a second op.
    bus.start_i       = 1'b1;
    bus.ALU_control_i = ALU_ADD;
    bus.src1_i        = 32'h10;
    bus.src2_i        = 32'h20;
    tick();
    bus.start_i = 1'b0;
    ndone   = 0;
    done_at = -1;
    for (int i = 1; i <= 75; i++) begin
      if (i == 10) begin
        bus.start_i       = 1'b1;
        bus.ALU_control_i = ALU_AND;
        bus.src1_i        = 32'h0;
      end
      tick();
      if (i == 10) bus.start_i = 1'b0;
      if (bus.done_o) begin
        ndone++;
        if (done_at < 0) done_at = i;
      end
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_done_at", done_at, 33);
    chk("ign_res", bus.result_o, 32'h30);

    // Reset in cycle 15 discards the operation.
    bus.start_i       = 1'b1;
    bus.ALU_control_i = ALU_ADD;
    bus.src1_i        = 32'h1;
    bus.src2_i        = 32'h2;
    tick();
    bus.start_i = 1'b0;
    for (int i = 1; i <= 14; i++) tick();
    chk("rstmid_busy_before", bus.busy_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_busy", bus.busy_o, 0);
    chk("rstmid_res", bus.result_o, 0);
    chk("rstmid_zero", bus.zero_o, 1);
    ndone = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.done_o) ndone++;
    end
    chk("rstmid_nodone", ndone, 0);

`ifdef ALU_SERIAL_ABORT_EN
    do_op(ALU_ADD, 32'h1, 32'h1, lat);
    chk("abort_prior", bus.result_o, 32'h2);
    bus.start_i       = 1'b1;
    bus.ALU_control_i = ALU_SUB;
    bus.src1_i        = 32'h9;
    bus.src2_i        = 32'h3;
    tick();
    bus.start_i = 1'b0;
    for (int i = 1; i <= 19; i++) tick();
    chk("abort_busy_before", bus.busy_o, 1);
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk("abort_busy", bus.busy_o, 0);
    ndone = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.done_o) ndone++;
    end
    chk("abort_nodone", ndone, 0);
    chk("abort_hold", bus.result_o, 32'h2);
    do_op(ALU_ADD, 32'h3, 32'h4, lat);
    chk("abort_next_lat", lat, 33);
    chk("abort_next_res", bus.result_o, 32'h7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
Multi-cycle sequencer that computes a full WIDTH-bit ALU operation by driving one 1-bit ALU slice (alu_top) once per clock, LSB first. It latches operands and opcode on start, then steps the slice through every bit, carrying the carry-out between cycles. For SLT it adds a finalise cycle. It returns the result and flags with a done pulse. It is the area-minimal alternative to the 32-slice ripple ALU and uses the same ALU_control encoding.

Parameters:
WIDTH, 32, operand/result width; legal range 2..64.
CNT_W, $clog2(WIDTH), width of the bit-index counter (derived; not overridden).

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous, active-high reset
start_i  input  1  request; sampled only in IDLE
ALU_control_i  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
src1_i  input  WIDTH  operand A, captured on accepted start
src2_i  input  WIDTH  operand B, captured on accepted start
busy_o  output  1  high in RUN and FIX
done_o  output  1  one-cycle pulse when outputs become valid
result_o  output  WIDTH  result, held until next done
zero_o  output  1  result_o == 0
cout_o  output  1  carry out of MSB (ADD/SUB only, else 0)
overflow_o  output  1  signed overflow (ADD/SUB only, else 0)

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: state=IDLE, busy_o=0, done_o=0, result_o=0, zero_o=1, cout_o=0, overflow_o=0. Internal operand, carry and counter registers are 0.
- FSM: IDLE -> RUN on start_i. RUN -> FIX after bit WIDTH-1 if op=SLT, else RUN -> DONE. FIX -> DONE. DONE -> IDLE unconditionally.
- On accept: latch A, B and op; counter=0; carry = B_invert.
- Slice drive per op:
  - AND: operation 00, inverts 0/0.
  - OR: operation 01, inverts 0/0.
  - ADD: operation 10, inverts 0/0.
  - SUB and SLT: operation 10, A_invert 0, B_invert 1.
  - NOR: operation 00, inverts 1/1.
  - Operation 11 is never driven. The slice less input is tied to 0.
- RUN:
  - Each cycle, feed A[0] and B[0] to the slice, then shift A and B right by 1.
  - Shift the slice result into the MSB of the result shift register.
  - Carry register <= slice cout.
  - Counter increments.
- At bit WIDTH-1 (ADD/SUB/SLT): capture overflow = carry-in ^ carry-out of the MSB, and capture the final carry.
- FIX (SLT only): result = {WIDTH-1 zeros, sum[MSB] ^ overflow}. cout_o and overflow_o report 0 for SLT.
- DONE: copy the result and flags to the outputs, assert done_o for exactly 1 cycle, set zero_o from the new result.
- Latency, with start accepted at edge 0:
  - done_o is high in cycle WIDTH+1 for non-SLT ops.
  - done_o is high in cycle WIDTH+2 for SLT.
  - A new start is accepted no earlier than the cycle after DONE.
- start_i outside IDLE is ignored, not queued.
- Undefined ALU_control_i: runs with normal latency; result 0, zero_o 1, flags 0.
- Outputs change only in DONE. Between operations they hold the last completed result.
- rst_i mid-RUN/FIX: next cycle everything takes its reset values, the operation is discarded, and no done pulse occurs.
- Carry wrap-around: the MSB carry-out is never fed back; the carry register reinitialises on each start.

Optional Feature:
ALU_SERIAL_ABORT_EN
- Defined: adds input abort_i (1 bit). abort_i high in RUN or FIX -> IDLE on the next edge.
  - No done pulse; busy_o drops.
  - Outputs keep the previous completed values.
  - abort_i in IDLE or DONE has no effect.
  - abort_i and start_i together in IDLE: the start is accepted.
- Undefined: the port is absent; an operation always completes.

Decomposition:
- Shared package alu_pkg:
  - ALU_control encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR).
  - Slice operation codes (SLICE_AND=2'b00, SLICE_OR=2'b01, SLICE_ADD=2'b10).
  - FSM state typedef (IDLE, RUN, FIX, DONE).
- One sub-module: the existing 1-bit slice alu_top, instantiated once. The opcode decode to slice controls stays in this block.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> result_o 0x80000000, overflow_o 1, cout_o 0, zero_o 0, done_o high exactly in cycle 33.
- SUB 0x00000005 - 0x00000005 -> result_o 0, zero_o 1, cout_o 1, overflow_o 0. SUB 0 - 1 -> 0xFFFFFFFF, cout_o 0.
- SLT 0xFFFFFFFF vs 0x00000001 -> result_o 1. SLT 0x7FFFFFFF vs 0x80000000 -> result_o 0 (overflow path). done_o in cycle 34; cout_o and overflow_o 0.
- NOR 0xF0F0F0F0, 0x0F0F0F00 -> 0x0000000F. AND 0xFFFF0000, 0x0F0F0F0F -> 0x0F0F0000. OR -> 0xFFFF0F0F.
- start_i pulsed at cycle 10 of a running ADD -> ignored, a single done_o. rst_i at cycle 15 -> busy_o 0 next cycle, no done_o, result_o 0, zero_o 1.
- With ALU_SERIAL_ABORT_EN: abort_i at cycle 20 of SUB -> IDLE next cycle, no done_o, result_o keeps the prior value. A following ADD 3+4 -> 7.
